// File: rtl/serdes_align_if.sv
// PLL dynamic-phase and 1:4 IDDR gearbox control bundle.
// master = alignment controller, slave = primitive wrapper.
interface serdes_align_if;
  logic [1:0] pll_phasesel;
  logic       pll_phasedir;
  logic       pll_phasestep;
  logic       pll_phaseloadreg;
  logic       pll_lock;
  logic       iddr_start;
  logic       iddr_alignwd;
  logic       iddr_ready;
  logic [3:0] iddr_q;

  modport master (
    input  pll_lock,
    input  iddr_ready,
    input  iddr_q,
    output pll_phasesel,
    output pll_phasedir,
    output pll_phasestep,
    output pll_phaseloadreg,
    output iddr_start,
    output iddr_alignwd
  );

  modport slave (
    output pll_lock,
    output iddr_ready,
    output iddr_q,
    input  pll_phasesel,
    input  pll_phasedir,
    input  pll_phasestep,
    input  pll_phaseloadreg,
    input  iddr_start,
    input  iddr_alignwd
  );
endinterface

// File: rtl/serdes_align_ctrl.sv
// Link bring-up: PLL phase sweep against a training word,
// park on the widest eye centre, then word-align the gearbox.
module serdes_align_ctrl #(
  parameter logic [3:0] TRAIN_PATTERN = 4'b0011,
  parameter int         PHASE_STEPS   = 8,
  parameter logic [1:0] PHASE_SEL     = 2'd2,
  parameter int         SETTLE_CYCLES = 16,
  parameter int         CHECK_WORDS   = 32,
  parameter int         MAX_SLIPS     = 4
) (
  input  logic                   sync_clk,
  input  logic                   sync_reset,
  input  logic                   en,
  serdes_align_if.master         phy,
  output logic                   aligned,
  output logic                   fail,
  output logic [PHASE_STEPS-1:0] pass_map,
  output logic [3:0]             phase_idx,
  output logic                   busy
);
  localparam int CMAX = (SETTLE_CYCLES > CHECK_WORDS) ?
                        SETTLE_CYCLES : CHECK_WORDS;
  localparam int CW = $clog2(CMAX + 1);
  localparam int SW = $clog2(MAX_SLIPS + 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] CHECK_LAST  = CW'(CHECK_WORDS - 1);
  localparam logic [SW-1:0] SLIP_MAX    = SW'(MAX_SLIPS);
  localparam logic [3:0]    LAST_PH     = 4'(PHASE_STEPS - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_WAIT_LOCK, S_WAIT_READY, S_SETTLE, S_SWEEP,
    S_STEP, S_CHOOSE, S_RETARD, S_WORD, S_LOCKED, S_FAILED
  } state_e;

  state_e state_q, state_d, ret_q, ret_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0] first_q, first_d;
  logic ok_q, ok_d;
  logic [PHASE_STEPS-1:0] map_q, map_d;
  logic [3:0] phase_q, phase_d;
  logic [3:0] rcnt_q, rcnt_d;
  logic [SW-1:0] slips_q, slips_d;
  logic dir_q, dir_d;
  logic step_q, step_d;
  logic start_q, start_d;
  logic alignwd_q, alignwd_d;

  logic [3:0] sw_first;
  logic sw_acc, wd_acc;
  logic [4:0] run, best_len, best_start;
  logic [3:0] centre;

  function automatic logic is_rot(input logic [3:0] w);
    return (w == TRAIN_PATTERN) ||
           (w == {TRAIN_PATTERN[2:0], TRAIN_PATTERN[3]}) ||
           (w == {TRAIN_PATTERN[1:0], TRAIN_PATTERN[3:2]}) ||
           (w == {TRAIN_PATTERN[0], TRAIN_PATTERN[3:1]});
  endfunction

  // Longest run of passing phases; strict > keeps the lowest start on ties.
  always_comb begin
    run = '0;
    best_len = '0;
    best_start = '0;
    for (int i = 0; i < PHASE_STEPS; i++) begin
      if (map_q[i]) begin
        run = run + 5'd1;
        if (run > best_len) begin
          best_len = run;
          best_start = 5'(i) - run + 5'd1;
        end
      end else begin
        run = '0;
      end
    end
  end

  assign centre = 4'(best_start + ((best_len - 5'd1) >> 1));

  assign busy = !(state_q inside {S_IDLE, S_LOCKED, S_FAILED});

  always_comb begin
    state_d = state_q;
    ret_d = ret_q;
    cnt_d = cnt_q;
    first_d = first_q;
    ok_d = ok_q;
    map_d = map_q;
    phase_d = phase_q;
    rcnt_d = rcnt_q;
    slips_d = slips_q;
    dir_d = dir_q;
    step_d = 1'b0;
    start_d = 1'b0;
    alignwd_d = 1'b0;
    sw_first = (cnt_q == '0) ? phy.iddr_q : first_q;
    sw_acc = ((cnt_q == '0) ? is_rot(phy.iddr_q) : ok_q) &
             (phy.iddr_q == sw_first);
    wd_acc = ((cnt_q == '0) ? 1'b1 : ok_q) &
             (phy.iddr_q == TRAIN_PATTERN);
    unique case (state_q)
      S_IDLE:
        if (en) state_d = S_WAIT_LOCK;
      S_WAIT_LOCK:
        if (phy.pll_lock) begin
          start_d = 1'b1;
          state_d = S_WAIT_READY;
        end
      S_WAIT_READY:
        if (phy.iddr_ready) begin
          map_d = '0;
          phase_d = '0;
          cnt_d = '0;
          ret_d = S_SWEEP;
          state_d = S_SETTLE;
        end
      S_SETTLE:
        if (cnt_q == SETTLE_LAST) begin
          cnt_d = '0;
          state_d = ret_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      S_SWEEP: begin
        first_d = sw_first;
        ok_d = sw_acc;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CHECK_LAST) begin
          cnt_d = '0;
          for (int i = 0; i < PHASE_STEPS; i++)
            if (4'(i) == phase_q) map_d[i] = sw_acc;
          if (phase_q < LAST_PH) begin
            dir_d = 1'b0;
            phase_d = phase_q + 4'd1;
            ret_d = S_SWEEP;
            state_d = S_STEP;
          end else begin
            state_d = S_CHOOSE;
          end
        end
      end
      // dir_q was settled on entry, so it is stable here and in the pulse cycle.
      S_STEP: begin
        step_d = 1'b1;
        cnt_d = '0;
        state_d = S_SETTLE;
      end
      S_CHOOSE: begin
        slips_d = '0;
        dir_d = 1'b1;
        rcnt_d = LAST_PH - centre;
        state_d = (best_len == '0) ? S_FAILED : S_RETARD;
      end
      S_RETARD:
        if (rcnt_q == '0) begin
          cnt_d = '0;
          state_d = S_WORD;
        end else begin
          rcnt_d = rcnt_q - 4'd1;
          phase_d = phase_q - 4'd1;
          ret_d = S_RETARD;
          state_d = S_STEP;
        end
      S_WORD: begin
        ok_d = wd_acc;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CHECK_LAST) begin
          cnt_d = '0;
          if (wd_acc) begin
            state_d = S_LOCKED;
          end else if (slips_q < SLIP_MAX) begin
            alignwd_d = 1'b1;
            slips_d = slips_q + 1'b1;
            ret_d = S_WORD;
            state_d = S_SETTLE;
          end else begin
            state_d = S_FAILED;
          end
        end
      end
      S_LOCKED: ;
      S_FAILED: ;
      default: state_d = S_IDLE;
    endcase
    if (!en) begin
      state_d = S_IDLE;
      step_d = 1'b0;
      start_d = 1'b0;
      alignwd_d = 1'b0;
    end else if (!phy.pll_lock && (busy || state_q == S_LOCKED)) begin
      state_d = S_WAIT_LOCK;
      step_d = 1'b0;
      start_d = 1'b0;
      alignwd_d = 1'b0;
    end
  end

  always_ff @(posedge sync_clk) begin
    if (sync_reset) begin
      state_q <= S_IDLE;
      ret_q <= S_IDLE;
      cnt_q <= '0;
      first_q <= '0;
      ok_q <= 1'b0;
      map_q <= '0;
      phase_q <= '0;
      rcnt_q <= '0;
      slips_q <= '0;
      dir_q <= 1'b0;
      step_q <= 1'b0;
      start_q <= 1'b0;
      alignwd_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ret_q <= ret_d;
      cnt_q <= cnt_d;
      first_q <= first_d;
      ok_q <= ok_d;
      map_q <= map_d;
      phase_q <= phase_d;
      rcnt_q <= rcnt_d;
      slips_q <= slips_d;
      dir_q <= dir_d;
      step_q <= step_d;
      start_q <= start_d;
      alignwd_q <= alignwd_d;
    end
  end

  assign phy.pll_phasesel = PHASE_SEL;
  assign phy.pll_phasedir = dir_q;
  assign phy.pll_phasestep = step_q;
  assign phy.pll_phaseloadreg = 1'b0;
  assign phy.iddr_start = start_q;
  assign phy.iddr_alignwd = alignwd_q;

  // Lock or enable loss drops aligned in the cycle it is seen.
  assign aligned = (state_q == S_LOCKED) && phy.pll_lock && en;
  assign fail = (state_q == S_FAILED);
  assign pass_map = map_q;
  assign phase_idx = phase_q;
endmodule

// File: tb/tb_serdes_align_ctrl.sv
// Directed bench: PLL/IDDR behavioural model with a programmable eye
// window and word rotation, checked with immediate assertions.
module tb_serdes_align_ctrl;
  localparam logic [3:0] TRAIN = 4'b0011;

  logic clk = 1'b0;
  logic sync_reset;
  logic en;
  logic aligned, fail, busy;
  logic [7:0] pass_map;
  logic [3:0] phase_idx;

  serdes_align_if phy();

  serdes_align_ctrl dut (
    .sync_clk  (clk),
    .sync_reset(sync_reset),
    .en        (en),
    .phy       (phy),
    .aligned   (aligned),
    .fail      (fail),
    .pass_map  (pass_map),
    .phase_idx (phase_idx),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // model state (written only by the model process)
  int cyc = 0;
  int ph = 0;
  int n_adv = 0, n_ret = 0, n_align = 0, n_start = 0;
  int dir_bad = 0;
  int last_pulse = -1000, min_gap = 100000;
  int last_align = -1000, align_gap = 0;
  logic prev_dir = 1'b0;
  int k, r;
  logic [7:0] pp;

  // stimulus knobs (written only by the initial block)
  logic [7:0] mask = 8'h00;
  int rot_init = 0;
  logic slip_ok = 1'b1;
  int b_adv, b_ret, b_align, b_start;
  int base_align = 0;

  always @(negedge clk) begin
    cyc++;
    if (phy.pll_phasestep === 1'b1) begin
      if (phy.pll_phasedir) begin n_ret++; ph--; end
      else begin n_adv++; ph++; end
      if (phy.pll_phasedir !== prev_dir) dir_bad++;
      if (cyc - last_pulse < min_gap) min_gap = cyc - last_pulse;
      last_pulse = cyc;
    end
    if (phy.iddr_start === 1'b1) begin
      n_start++;
      ph = 0;
      if (cyc - last_pulse < min_gap) min_gap = cyc - last_pulse;
      last_pulse = cyc;
    end
    if (phy.iddr_alignwd === 1'b1) begin
      n_align++;
      align_gap = cyc - last_align;
      last_align = cyc;
      if (cyc - last_pulse < min_gap) min_gap = cyc - last_pulse;
      last_pulse = cyc;
    end
    prev_dir = phy.pll_phasedir;
    k = n_align - base_align;
    r = rot_init;
    if (slip_ok) r = (rot_init > k) ? rot_init - k : 0;
    pp = {TRAIN, TRAIN};
    pp = pp << r;
    if (ph >= 0 && ph < 8 && mask[ph]) phy.iddr_q = pp[7:4];
    else phy.iddr_q = 4'($urandom());
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic snap();
    b_adv = n_adv;
    b_ret = n_ret;
    b_align = n_align;
    b_start = n_start;
    base_align = n_align;
  endtask

  task automatic do_reset();
    en = 1'b0;
    sync_reset = 1'b1;
    tick(20);
    sync_reset = 1'b0;
    tick(1);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!(aligned || fail) && n < 4000) begin
      tick(1);
      n++;
    end
    chk({tag, "_done"}, 32'(aligned || fail), 1);
  endtask

  initial begin
    en = 1'b0;
    sync_reset = 1'b1;
    phy.pll_lock = 1'b1;
    phy.iddr_ready = 1'b1;
    tick(5);
    sync_reset = 1'b0;
    tick(1);
    chk("rst_phasesel", 32'(phy.pll_phasesel), 2);
    chk("rst_step", 32'(phy.pll_phasestep), 0);
    chk("rst_start", 32'(phy.iddr_start), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_aligned", 32'(aligned), 0);
    chk("rst_fail", 32'(fail), 0);
    chk("rst_passmap", 32'(pass_map), 0);
    chk("rst_phase", 32'(phase_idx), 0);
    chk("rst_loadreg", 32'(phy.pll_phaseloadreg), 0);

    // nominal: eye at phases 2..5, rotation 0
    mask = 8'b0011_1100; rot_init = 0; slip_ok = 1'b1;
    snap();
    en = 1'b1;
    wait_done("nom");
    chk("nom_aligned", 32'(aligned), 1);
    chk("nom_fail", 32'(fail), 0);
    chk("nom_passmap", 32'(pass_map), 32'h3C);
    chk("nom_phase", 32'(phase_idx), 3);
    chk("nom_adv", 32'(n_adv - b_adv), 7);
    chk("nom_ret", 32'(n_ret - b_ret), 4);
    chk("nom_align", 32'(n_align - b_align), 0);
    chk("nom_start", 32'(n_start - b_start), 1);
    chk("nom_busy", 32'(busy), 0);

    // lock loss while LOCKED, then relock
    phy.pll_lock = 1'b0;
    #1;
    chk("drop_aligned", 32'(aligned), 0);
    tick(1);
    chk("drop_busy", 32'(busy), 1);
    snap();
    tick(5);
    chk("drop_nostart", 32'(n_start - b_start), 0);
    phy.pll_lock = 1'b1;
    wait_done("relock");
    chk("relock_aligned", 32'(aligned), 1);
    chk("relock_start", 32'(n_start - b_start), 1);
    chk("relock_phase", 32'(phase_idx), 3);

    // word slip: rotation 2 needs two slips
    do_reset();
    mask = 8'b0011_1100; rot_init = 2; slip_ok = 1'b1;
    snap();
    en = 1'b1;
    wait_done("slip");
    chk("slip_aligned", 32'(aligned), 1);
    chk("slip_fail", 32'(fail), 0);
    chk("slip_align", 32'(n_align - b_align), 2);
    chk("slip_gap", 32'(align_gap >= 17), 1);

    // no eye anywhere
    do_reset();
    mask = 8'h00; rot_init = 0;
    snap();
    en = 1'b1;
    wait_done("noeye");
    chk("noeye_fail", 32'(fail), 1);
    chk("noeye_aligned", 32'(aligned), 0);
    chk("noeye_passmap", 32'(pass_map), 0);
    chk("noeye_adv", 32'(n_adv - b_adv), 7);
    chk("noeye_ret", 32'(n_ret - b_ret), 0);
    chk("noeye_align", 32'(n_align - b_align), 0);
    tick(10);
    chk("noeye_sticky", 32'(fail), 1);
    en = 1'b0;
    tick(1);
    chk("noeye_clr_fail", 32'(fail), 0);
    chk("noeye_idle", 32'(busy), 0);

    // slip exhaustion: model ignores alignwd
    do_reset();
    mask = 8'b0011_1100; rot_init = 1; slip_ok = 1'b0;
    snap();
    en = 1'b1;
    wait_done("exh");
    chk("exh_fail", 32'(fail), 1);
    chk("exh_aligned", 32'(aligned), 0);
    chk("exh_align", 32'(n_align - b_align), 4);

    // tie between {0,1} and {5,6}: lowest start wins, centre 0
    do_reset();
    mask = 8'b0110_0011; rot_init = 0; slip_ok = 1'b1;
    snap();
    en = 1'b1;
    wait_done("tie");
    chk("tie_aligned", 32'(aligned), 1);
    chk("tie_passmap", 32'(pass_map), 32'h63);
    chk("tie_ret", 32'(n_ret - b_ret), 7);
    chk("tie_phase", 32'(phase_idx), 0);

    // reset in the middle of the sweep
    do_reset();
    mask = 8'b0011_1100;
    en = 1'b1;
    tick(150);
    chk("mid_busy", 32'(busy), 1);
    sync_reset = 1'b1;
    tick(1);
    snap();
    chk("mid_busy_rst", 32'(busy), 0);
    chk("mid_phase_rst", 32'(phase_idx), 0);
    chk("mid_map_rst", 32'(pass_map), 0);
    chk("mid_dir_rst", 32'(phy.pll_phasedir), 0);
    chk("mid_sel_rst", 32'(phy.pll_phasesel), 2);
    tick(30);
    chk("mid_nopulse",
        32'((n_adv - b_adv) + (n_ret - b_ret) +
            (n_align - b_align) + (n_start - b_start)), 0);
    sync_reset = 1'b0;
    tick(2);

    chk("dir_stable", 32'(dir_bad), 0);
    chk("pulse_gap", 32'(min_gap >= 17), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/serdes_align_ctrl.md
Name: serdes_align_ctrl

Overview:
- Link-bringup controller for the 1:4 IDDR gearbox and its dynamic-phase PLL.
- Sequence: waits for PLL lock, starts the IDDR, then sweeps the PLL output phase against a known 4-bit training word and parks on the centre of the widest passing window.
- Then issues word-align slips until the gearbox output equals the training word, and asserts aligned.
- Sits between the PLL/IDDR primitive wrapper and the receive datapath.

Parameters:
- TRAIN_PATTERN, 4'b0011, training word; all four rotations are distinct.
- PHASE_STEPS, 8, PLL phase steps per full rotation; sweep length; max 16.
- PHASE_SEL, 2'd2, PLL output selected for phase shift (driven on pll_phasesel).
- SETTLE_CYCLES, 16, wait after each phase step, start or slip before sampling.
- CHECK_WORDS, 32, consecutive words sampled per check.
- MAX_SLIPS, 4, word-align attempts before failure.

Ports:
- sync_clk, in, 1, controller clock; equals the IDDR sclk, so iddr_q is synchronous to it.
- sync_reset, in, 1, synchronous active-high reset.
- en, in, 1, level; 0 forces IDLE and clears fail.
- pll_lock, in, 1, PLL lock (pre-synchronised).
- pll_phasesel, out, 2, constant PHASE_SEL.
- pll_phasedir, out, 1, 0 = advance, 1 = retard.
- pll_phasestep, out, 1, one-cycle step pulse.
- pll_phaseloadreg, out, 1, held 0.
- iddr_start, out, 1, one-cycle gearbox start pulse.
- iddr_alignwd, out, 1, one-cycle word-slip pulse.
- iddr_ready, in, 1, gearbox ready.
- iddr_q, in, 4, gearbox output word.
- aligned, out, 1, link trained.
- fail, out, 1, sticky training failure.
- pass_map, out, PHASE_STEPS, per-phase pass result of last sweep.
- phase_idx, out, 4, current phase position.
- busy, out, 1, 1 in any state other than IDLE, LOCKED or FAILED.

Behaviour:
- Reset: all outputs 0, except pll_phasesel = PHASE_SEL; state IDLE; phase_idx = 0.
- Reset mid-operation: aborts immediately; no further pulses are issued.
- Interval rule: any two step/start/alignwd pulses are at least SETTLE_CYCLES+1 cycles apart.
- IDLE: when en=1, go to WAIT_LOCK.
- WAIT_LOCK: when pll_lock=1, pulse iddr_start one cycle, then go to WAIT_READY.
- WAIT_READY: when iddr_ready=1, wait SETTLE_CYCLES, then go to SWEEP_CHECK with phase_idx=0.
- SWEEP_CHECK: sample CHECK_WORDS consecutive words. Phase passes iff every word equals the first sampled word AND that word is a rotation of TRAIN_PATTERN. Write the result to pass_map[phase_idx].
  - If phase_idx < PHASE_STEPS-1: go to STEP with pll_phasedir=0, phase_idx+1.
  - Otherwise go to CHOOSE.
- STEP: pulse pll_phasestep one cycle with pll_phasedir stable in that cycle and the cycle before. Wait SETTLE_CYCLES, then return to the calling state.
- CHOOSE: find the longest contiguous run of 1s in pass_map.
  - No wrap-around; ties resolve to the lowest start.
  - centre = start + (len-1)>>1.
  - No passing phase: go to FAILED.
  - Otherwise retard (PHASE_STEPS-1-centre) steps; phase_idx decrements per step. Zero steps is legal.
  - Then go to WORD_CHECK.
- WORD_CHECK: sample CHECK_WORDS words.
  - All equal TRAIN_PATTERN: go to LOCKED.
  - Otherwise, if slips < MAX_SLIPS: pulse iddr_alignwd, increment slips, wait SETTLE_CYCLES, recheck.
  - Otherwise go to FAILED.
  - Slips counter clears on entry from CHOOSE.
- LOCKED: aligned=1.
  - pll_lock=0 or en=0: aligned=0 in the same cycle the state leaves. pll_lock=0 goes to WAIT_LOCK; en=0 goes to IDLE.
  - On re-entry, pass_map clears and phase_idx=0 once iddr_ready is seen; the PLL phase position is not tracked across lock loss.
- FAILED: fail=1 and is sticky. Leaves only via en=0 (to IDLE) or reset.
- pll_lock loss in any busy state: abort to WAIT_LOCK.
- en=0 in any state: go to IDLE next cycle.

Test Plan:
- Nominal: iddr_q model passes at phases 2..5 → pass_map=8'b00111100; centre 3; exactly 4 retard pulses with pll_phasedir=1; rotation 0 → zero alignwd pulses; aligned=1.
- Word slip: same window, model output rotated by 2 until slipped → exactly 2 alignwd pulses ≥17 cycles apart; aligned=1, fail=0.
- No eye: random iddr_q at all phases → 7 advance pulses; pass_map=0; fail=1, aligned=0, no alignwd pulse. Then en=0 → fail=0 and state IDLE.
- Slip exhaustion: model ignores alignwd → exactly 4 alignwd pulses, then fail=1.
- Tie/edge: pass at phases {0,1} and {5,6} → centre 0; 7 retard pulses; phase_idx=0.
- Disruption: pll_lock drops in LOCKED → aligned=0 the same cycle; new iddr_start after relock. sync_reset mid-sweep → all pulses stop and outputs return to reset values next cycle.
